mat_cache: RTL and testbench
============================

// Module: mat_cache
// PURPOSE
//  Register-file store of CACHE_SIZE square WIDTH x WIDTH matrices of shortreal; sits beside the matrix unit.
//  Each cycle one WIDTH-wide vector is written (row or column) on the clock edge.
//  One WIDTH-wide vector is read combinationally (row, column or rotated diagonal) for systolic feeding.
// PARAMETERS
//  WIDTH       4  matrix dimension; also vector length of data_in/data_out
//  CACHE_SIZE  4  number of matrices held
// PORTS
//  Clock is `clock`. Reset is `reset`: synchronous, active-high.
//  clock        in   1                    rising-edge clock
//  reset        in   1                    sync active-high; clears all matrices
//  read_op      in   MatDataReadOp_t      NONE/ROW/COL/DIAG
//  read_addr1   in   $clog2(CACHE_SIZE)   matrix index for read
//  read_addr2   in   $clog2(CACHE_SIZE)   reserved second read matrix; ignored by current ops
//  read_param   in   $clog2(WIDTH)        row/col/diagonal selector for read
//  write_op     in   MatDataWriteOp_t     NONE/ROW/COL
//  write_addr1  in   $clog2(CACHE_SIZE)   matrix index for write
//  write_addr2  in   $clog2(CACHE_SIZE)   reserved; ignored
//  write_param  in   $clog2(WIDTH)        row/col selector for write
//  data_in      in   shortreal[WIDTH]     write vector
//  data_out     out  shortreal[WIDTH]     read vector (combinational)
// BEHAVIOUR
//  Storage M[a][r][c], a<CACHE_SIZE, r,c<WIDTH.
//  Reset: at posedge with reset=1 every element := 0.0. Reset has priority over a same-cycle write.
//  Write, at posedge when reset=0, a=write_addr1, p=write_param:
//   - WRITE_ROW: M[a][p][j] := data_in[j] for all j
//   - WRITE_COL: M[a][j][p] := data_in[j] for all j
//   - WRITE_NONE: no change
//  Read, purely combinational with zero latency, a=read_addr1, p=read_param:
//   - READ_ROW:  data_out[j] = M[a][p][j]
//   - READ_COL:  data_out[j] = M[a][j][p]
//   - READ_DIAG: data_out[i] = M[a][i][(p - i) mod WIDTH]  (anti-diagonal rotated by p)
//   - READ_NONE: all 0.0
//  data_out reflects stored state only; a write in the same cycle is visible after the edge.
//  Read-after-write of the same location returns the new value from the cycle after the write.
//  Address >= CACHE_SIZE (non-pow2 sizes): write ignored, read returns 0.0.
//  Index arithmetic is modulo WIDTH via unsigned wrap of $clog2(WIDTH)-bit values; WIDTH must be a power of 2.
//  Repeated identical writes are idempotent.
// STRUCTURE
//  Package MatPkg:
//   - typedef enum MatDataReadOp_t {MAT_DATA_READ_NONE, MAT_DATA_READ_ROW, MAT_DATA_READ_COL, MAT_DATA_READ_DIAG}
//   - typedef enum MatDataWriteOp_t {MAT_DATA_WRITE_NONE, MAT_DATA_WRITE_ROW, MAT_DATA_WRITE_COL}
//  Single flat module: one always_ff for reset/write, one always_comb read mux. No sub-modules.
// TESTING
//  1. Reset, then READ_ROW of any address/param -> all 0.0.
//  2. Matrix 0: WRITE_ROW p=0..3 with (4,6,1,6),(1,2,3,4),(3,3,3,3),(9,7,5,3), then READ_DIAG a=0:
//     - p=0 -> (4,4,3,7)
//     - p=1 -> (6,1,3,5)
//     - p=2 -> (1,2,3,3)
//     - p=3 -> (6,3,3,9)
//  3. Matrix 2: WRITE_COL p=1:(1,2,3,4), p=0:(3,3,3,3), p=3:(9,7,8,3), p=2:(9,7,5,3), then READ_ROW a=2:
//     - p=0 -> (3,1,9,9)
//     - p=1 -> (3,2,7,7)
//     - p=2 -> (3,3,5,8)
//     - p=3 -> (3,4,3,3)
//  4. After test 3, READ_ROW a=0 p=3 -> (9,7,5,3); matrix 0 untouched by matrix 2 writes.
//  5. READ_COL a=2 p=3 -> (9,7,8,3); READ_NONE -> all 0.0.
//  6. Assert reset with WRITE_ROW a=1 p=0 (1,1,1,1) -> after edge READ_ROW a=1 p=0 = (0,0,0,0).

Source files
------------

// File: rtl/mat_cache_pkg.sv
// Shared operation encodings for the matrix cache.
package MatPkg;

  typedef enum logic [1:0] {
    MAT_DATA_READ_NONE,
    MAT_DATA_READ_ROW,
    MAT_DATA_READ_COL,
    MAT_DATA_READ_DIAG
  } MatDataReadOp_t;

  typedef enum logic [1:0] {
    MAT_DATA_WRITE_NONE,
    MAT_DATA_WRITE_ROW,
    MAT_DATA_WRITE_COL
  } MatDataWriteOp_t;

endpackage

// File: rtl/mat_cache.sv
// Register-file store of CACHE_SIZE square WIDTH x WIDTH shortreal matrices.
// One row/column vector written per clock; one row/column/rotated
// anti-diagonal vector read combinationally for systolic feeding.
module mat_cache
  import MatPkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CACHE_SIZE = 4,
  localparam int unsigned AW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  MatDataReadOp_t  read_op,
  input  logic [AW-1:0]   read_addr1,
  input  logic [AW-1:0]   read_addr2,
  input  logic [PW-1:0]   read_param,
  input  MatDataWriteOp_t write_op,
  input  logic [AW-1:0]   write_addr1,
  input  logic [AW-1:0]   write_addr2,
  input  logic [PW-1:0]   write_param,
  input  shortreal        data_in  [WIDTH],
  output shortreal        data_out [WIDTH]
);

  localparam bit ADDR_FULL = ((1 << AW) == CACHE_SIZE);

  shortreal mem [CACHE_SIZE][WIDTH][WIDTH];

  logic read_valid;
  logic write_valid;

  // Second address ports are reserved for future two-operand ops.
  logic unused_addr2;
  assign unused_addr2 = ^{read_addr2, write_addr2};

  // Out-of-range addresses only exist for non-power-of-2 cache sizes.
  if (ADDR_FULL) begin : g_full
    assign read_valid  = 1'b1;
    assign write_valid = 1'b1;
  end else begin : g_partial
    assign read_valid  = (int'(read_addr1)  < CACHE_SIZE);
    assign write_valid = (int'(write_addr1) < CACHE_SIZE);
  end

  // Storage update: reset clears everything and overrides any write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned a = 0; a < CACHE_SIZE; a++)
        for (int unsigned r = 0; r < WIDTH; r++)
          for (int unsigned c = 0; c < WIDTH; c++)
            mem[a][r][c] <= 0.0;
    end else if (write_valid) begin
      case (write_op)
        MAT_DATA_WRITE_ROW:
          for (int unsigned j = 0; j < WIDTH; j++)
            mem[write_addr1][write_param][PW'(j)] <= data_in[j];
        MAT_DATA_WRITE_COL:
          for (int unsigned j = 0; j < WIDTH; j++)
            mem[write_addr1][PW'(j)][write_param] <= data_in[j];
        default: ;
      endcase
    end
  end

  // Zero-latency read mux; diagonal column index wraps modulo WIDTH.
  always_comb begin
    for (int unsigned j = 0; j < WIDTH; j++) data_out[j] = 0.0;
    if (read_valid) begin
      case (read_op)
        MAT_DATA_READ_ROW:
          for (int unsigned j = 0; j < WIDTH; j++)
            data_out[j] = mem[read_addr1][read_param][PW'(j)];
        MAT_DATA_READ_COL:
          for (int unsigned j = 0; j < WIDTH; j++)
            data_out[j] = mem[read_addr1][PW'(j)][read_param];
        MAT_DATA_READ_DIAG:
          for (int unsigned i = 0; i < WIDTH; i++)
            data_out[i] = mem[read_addr1][PW'(i)][PW'(read_param - PW'(i))];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_cache.sv
// Directed bench for mat_cache with hand-computed expected vectors.
module tb_mat_cache;
  import MatPkg::*;

  logic            clock;
  logic            reset;
  MatDataReadOp_t  read_op;
  logic [1:0]      read_addr1;
  logic [1:0]      read_addr2;
  logic [1:0]      read_param;
  MatDataWriteOp_t write_op;
  logic [1:0]      write_addr1;
  logic [1:0]      write_addr2;
  logic [1:0]      write_param;
  shortreal        data_in  [4];
  shortreal        data_out [4];

  int total;
  int bad;

  mat_cache #(.WIDTH(4), .CACHE_SIZE(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .read_op     (read_op),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .read_param  (read_param),
    .write_op    (write_op),
    .write_addr1 (write_addr1),
    .write_addr2 (write_addr2),
    .write_param (write_param),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clocked write; inputs change on the falling edge, settle after posedge.
  task automatic do_write(input MatDataWriteOp_t op, input logic [1:0] a,
                          input logic [1:0] p, input shortreal v [4],
                          input logic rst);
    @(negedge clock);
    write_op    = op;
    write_addr1 = a;
    write_param = p;
    data_in     = v;
    reset       = rst;
    @(posedge clock);
    #1;
    write_op = MAT_DATA_WRITE_NONE;
    reset    = 1'b0;
  endtask

  // Combinational read and compare of the whole vector.
  task automatic check_read(input string tag, input MatDataReadOp_t op,
                            input logic [1:0] a, input logic [1:0] p,
                            input shortreal e [4]);
    logic ok;
    read_op    = op;
    read_addr1 = a;
    read_param = p;
    #1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (data_out[i] != e[i]) ok = 1'b0;
    total++;
    assert (ok === 1'b1)
    else begin
      bad++;
      $error("FAIL %s: observed=(%0.1f,%0.1f,%0.1f,%0.1f) expected=(%0.1f,%0.1f,%0.1f,%0.1f)",
             tag, data_out[0], data_out[1], data_out[2], data_out[3],
             e[0], e[1], e[2], e[3]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset       = 1'b1;
    read_op     = MAT_DATA_READ_NONE;
    read_addr1  = '0;
    read_addr2  = '0;
    read_param  = '0;
    write_op    = MAT_DATA_WRITE_NONE;
    write_addr1 = '0;
    write_addr2 = '0;
    write_param = '0;
    data_in     = '{0.0, 0.0, 0.0, 0.0};
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check_read("rst_row_a0p0", MAT_DATA_READ_ROW, 2'd0, 2'd0, '{0.0, 0.0, 0.0, 0.0});
    check_read("rst_row_a3p2", MAT_DATA_READ_ROW, 2'd3, 2'd2, '{0.0, 0.0, 0.0, 0.0});

    // Matrix 0 by rows, read rotated anti-diagonals
    do_write(MAT_DATA_WRITE_ROW, 2'd0, 2'd0, '{4.0, 6.0, 1.0, 6.0}, 1'b0);
    do_write(MAT_DATA_WRITE_ROW, 2'd0, 2'd1, '{1.0, 2.0, 3.0, 4.0}, 1'b0);
    do_write(MAT_DATA_WRITE_ROW, 2'd0, 2'd2, '{3.0, 3.0, 3.0, 3.0}, 1'b0);
    do_write(MAT_DATA_WRITE_ROW, 2'd0, 2'd3, '{9.0, 7.0, 5.0, 3.0}, 1'b0);
    check_read("diag_p0", MAT_DATA_READ_DIAG, 2'd0, 2'd0, '{4.0, 4.0, 3.0, 7.0});
    check_read("diag_p1", MAT_DATA_READ_DIAG, 2'd0, 2'd1, '{6.0, 1.0, 3.0, 5.0});
    check_read("diag_p2", MAT_DATA_READ_DIAG, 2'd0, 2'd2, '{1.0, 2.0, 3.0, 3.0});
    check_read("diag_p3", MAT_DATA_READ_DIAG, 2'd0, 2'd3, '{6.0, 3.0, 3.0, 9.0});

    // Matrix 2 by columns, read rows
    do_write(MAT_DATA_WRITE_COL, 2'd2, 2'd1, '{1.0, 2.0, 3.0, 4.0}, 1'b0);
    do_write(MAT_DATA_WRITE_COL, 2'd2, 2'd0, '{3.0, 3.0, 3.0, 3.0}, 1'b0);
    do_write(MAT_DATA_WRITE_COL, 2'd2, 2'd3, '{9.0, 7.0, 8.0, 3.0}, 1'b0);
    do_write(MAT_DATA_WRITE_COL, 2'd2, 2'd2, '{9.0, 7.0, 5.0, 3.0}, 1'b0);
    check_read("m2_row_p0", MAT_DATA_READ_ROW, 2'd2, 2'd0, '{3.0, 1.0, 9.0, 9.0});
    check_read("m2_row_p1", MAT_DATA_READ_ROW, 2'd2, 2'd1, '{3.0, 2.0, 7.0, 7.0});
    check_read("m2_row_p2", MAT_DATA_READ_ROW, 2'd2, 2'd2, '{3.0, 3.0, 5.0, 8.0});
    check_read("m2_row_p3", MAT_DATA_READ_ROW, 2'd2, 2'd3, '{3.0, 4.0, 3.0, 3.0});

    // Isolation between matrices, column read, NONE read
    check_read("m0_row_p3", MAT_DATA_READ_ROW, 2'd0, 2'd3, '{9.0, 7.0, 5.0, 3.0});
    check_read("m0_col_p1", MAT_DATA_READ_COL, 2'd0, 2'd1, '{6.0, 2.0, 3.0, 7.0});
    check_read("m2_col_p3", MAT_DATA_READ_COL, 2'd2, 2'd3, '{9.0, 7.0, 8.0, 3.0});
    check_read("read_none", MAT_DATA_READ_NONE, 2'd2, 2'd3, '{0.0, 0.0, 0.0, 0.0});
    check_read("m1_untouched", MAT_DATA_READ_ROW, 2'd1, 2'd0, '{0.0, 0.0, 0.0, 0.0});

    // WRITE_NONE leaves data alone; repeated identical write is idempotent
    do_write(MAT_DATA_WRITE_NONE, 2'd0, 2'd3, '{1.0, 1.0, 1.0, 1.0}, 1'b0);
    check_read("wnone_keep", MAT_DATA_READ_ROW, 2'd0, 2'd3, '{9.0, 7.0, 5.0, 3.0});
    do_write(MAT_DATA_WRITE_ROW, 2'd3, 2'd1, '{2.5, 0.5, 8.0, 1.0}, 1'b0);
    do_write(MAT_DATA_WRITE_ROW, 2'd3, 2'd1, '{2.5, 0.5, 8.0, 1.0}, 1'b0);
    check_read("idem_row", MAT_DATA_READ_ROW, 2'd3, 2'd1, '{2.5, 0.5, 8.0, 1.0});
    check_read("idem_col", MAT_DATA_READ_COL, 2'd3, 2'd2, '{0.0, 8.0, 0.0, 0.0});

    // Reset wins over a same-cycle write and clears every matrix
    do_write(MAT_DATA_WRITE_ROW, 2'd1, 2'd0, '{1.0, 1.0, 1.0, 1.0}, 1'b1);
    check_read("rst_prio_m1", MAT_DATA_READ_ROW, 2'd1, 2'd0, '{0.0, 0.0, 0.0, 0.0});
    check_read("rst_clr_m0", MAT_DATA_READ_ROW, 2'd0, 2'd3, '{0.0, 0.0, 0.0, 0.0});
    check_read("rst_clr_m2", MAT_DATA_READ_COL, 2'd2, 2'd3, '{0.0, 0.0, 0.0, 0.0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
